// File: rtl/enc_period_meter.sv
// ---------------------------------------------------------------------------
// enc_period_meter
//
// Single-channel encoder period meter. The raw encoder pin is brought into
// the clk domain by a 2-FF synchroniser, cleaned up by a programmable glitch
// filter, and edge-detected. The number of clk cycles between consecutive
// qualifying edges (rising only, or rising and falling) is reported as a
// period with a one-cycle valid strobe. A long gap with no edge saturates
// the interval counter and raises a timeout level.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   enc          in   raw asynchronous encoder signal
//   filt_thr     in   filter threshold in clk cycles (0 = one-register bypass)
//   both_edges   in   0: rising edges qualify; 1: rising and falling qualify
//   enc_filt     out  filtered encoder level
//   period       out  last measured interval in clk cycles
//   period_valid out  one-cycle strobe when period updates
//   timeout      out  level; interval counter saturated without an event
//   edge_cnt     out  qualified-event counter, wraps modulo 2^ECNT_W
//
// Latency from pin to enc_filt is 2 + filt_thr + 1 cycles. ev is a
// combinational decode of enc_filt against its registered copy, so it is
// high during the cycle after enc_filt changes; period and period_valid
// follow one cycle later.
// ---------------------------------------------------------------------------
module enc_period_meter #(
  parameter int CNT_W  = 16,
  parameter int FILT_W = 14,
  parameter int ECNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enc,
  input  logic [FILT_W-1:0] filt_thr,
  input  logic              both_edges,
  output logic              enc_filt,
  output logic [CNT_W-1:0]  period,
  output logic              period_valid,
  output logic              timeout,
  output logic [ECNT_W-1:0] edge_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for the first edge to arm a measurement
    MEAS  = 2'd1,  // counting cycles since the last qualified edge
    STALL = 2'd2   // counter saturated; next edge re-arms without a result
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // -------------------------------------------------------------------------
  // Input conditioning: synchroniser, glitch filter, edge detect
  // -------------------------------------------------------------------------
  logic              sync_1;
  logic              sync_2;
  logic [FILT_W-1:0] fc;
  logic              enc_filt_d;
  logic              rise;
  logic              fall;
  logic              ev;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      fc         <= '0;
      enc_filt   <= 1'b0;
      enc_filt_d <= 1'b0;
      edge_cnt   <= '0;
    end else begin
      sync_1 <= enc;
      sync_2 <= sync_1;

      // fc counts consecutive cycles where the synchronised input disagrees
      // with the filtered level; any agreement restarts the count. The new
      // level is accepted once it has been seen for filt_thr+1 cycles. The
      // >= compare means a threshold lowered below the running count accepts
      // at once instead of waiting for fc to wrap.
      if (sync_2 != enc_filt) begin
        if (fc >= filt_thr) begin
          enc_filt <= sync_2;
          fc       <= '0;
        end else begin
          fc <= fc + 1'b1;
        end
      end else begin
        fc <= '0;
      end

      enc_filt_d <= enc_filt;

      // Counts every qualified event regardless of measurement state.
      if (ev) begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

  assign rise = enc_filt & ~enc_filt_d;
  assign fall = ~enc_filt & enc_filt_d;
  assign ev   = rise | (both_edges & fall);

  // -------------------------------------------------------------------------
  // Interval measurement FSM
  // -------------------------------------------------------------------------
  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic [CNT_W-1:0]  period_n;
  logic              period_valid_n;
  logic              timeout_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      period       <= period_n;
      period_valid <= period_valid_n;
      timeout      <= timeout_n;
    end
  end

  // cnt is 1 in the cycle after an event, so when the next event arrives it
  // holds exactly the number of cycles between the two events.
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    period_n       = period;
    period_valid_n = 1'b0;
    timeout_n      = timeout;

    unique case (state)
      IDLE: begin
        // The first edge only arms the measurement.
        if (ev) begin
          state_n = MEAS;
          cnt_n   = CNT_ONE;
        end
      end

      MEAS: begin
        // An event on the saturation cycle still reports a full-scale
        // period rather than a timeout.
        if (ev) begin
          period_n       = cnt;
          period_valid_n = 1'b1;
          cnt_n          = CNT_ONE;
        end else if (cnt == CNT_MAX) begin
          state_n   = STALL;
          timeout_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      STALL: begin
        // The interval that spanned the stall is unknown, so re-arm without
        // a result; cnt stays parked at full scale until then.
        if (ev) begin
          state_n   = MEAS;
          cnt_n     = CNT_ONE;
          timeout_n = 1'b0;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_enc_period_meter.sv
module tb_enc_period_meter;

  localparam int CNT_W  = 8;
  localparam int FILT_W = 14;
  localparam int ECNT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              enc;
  logic [FILT_W-1:0] filt_thr;
  logic              both_edges;
  logic              enc_filt;
  logic [CNT_W-1:0]  period;
  logic              period_valid;
  logic              timeout;
  logic [ECNT_W-1:0] edge_cnt;

  enc_period_meter #(
    .CNT_W (CNT_W),
    .FILT_W(FILT_W),
    .ECNT_W(ECNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enc         (enc),
    .filt_thr    (filt_thr),
    .both_edges  (both_edges),
    .enc_filt    (enc_filt),
    .period      (period),
    .period_valid(period_valid),
    .timeout     (timeout),
    .edge_cnt    (edge_cnt)
  );

  always #5 clk = ~clk;

  // Square-wave scenario: threshold, edge mode, high/low lengths, cycles.
  typedef struct {
    int thr;
    bit both;
    int hi;
    int lo;
    int n;
  } vec_t;

  vec_t vecs[5];
  int   total = 0;
  int   bad   = 0;
  int   exp_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: scoreboard monitor at the falling edge, then return just
  // after the rising edge where the caller drives inputs and samples.
  task automatic step();
    @(negedge clk);
    if (period_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_valid", {31'd0, period_valid}, 0);
      else                   check("period_on_valid", {24'd0, period}, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enc = 1'b0;
    steps(2);
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    bit seen;
    int rise_at;

    rst        = 1'b1;
    enc        = 1'b1;
    both_edges = 1'b0;
    filt_thr   = '0;

    // Reset state, with the pin held high so the filter must stay cleared.
    steps(4);
    check("rst_enc_filt",     {31'd0, enc_filt}, 0);
    check("rst_period",       {24'd0, period}, 0);
    check("rst_period_valid", {31'd0, period_valid}, 0);
    check("rst_timeout",      {31'd0, timeout}, 0);
    check("rst_edge_cnt",     {28'd0, edge_cnt}, 0);
    enc = 1'b0;
    steps(4);
    rst = 1'b0;

    // Table-driven square waves.
    vecs[0] = '{thr: 0, both: 1'b0, hi: 50, lo: 50, n: 4};
    vecs[1] = '{thr: 0, both: 1'b1, hi: 30, lo: 70, n: 3};
    vecs[2] = '{thr: 5, both: 1'b0, hi: 20, lo: 37, n: 4};
    vecs[3] = '{thr: 3, both: 1'b1, hi: 12, lo: 25, n: 3};
    vecs[4] = '{thr: 0, both: 1'b1, hi: 8,  lo: 8,  n: 10};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      filt_thr   = FILT_W'(vecs[i].thr);
      both_edges = vecs[i].both;
      steps(10);
      for (int k = 0; k < vecs[i].n; k++) begin
        enc = 1'b1;
        if (k > 0) exp_q.push_back(vecs[i].both ? vecs[i].lo : vecs[i].hi + vecs[i].lo);
        steps(vecs[i].hi);
        enc = 1'b0;
        if (vecs[i].both) exp_q.push_back(vecs[i].hi);
        steps(vecs[i].lo);
      end
      steps(10);
      check($sformatf("row%0d_edge_cnt", i), {28'd0, edge_cnt},
            ((vecs[i].both ? 2 : 1) * vecs[i].n) % 16);
      check($sformatf("row%0d_pending", i), exp_q.size(), 0);
      check($sformatf("row%0d_timeout", i), {31'd0, timeout}, 0);
    end

    // Glitch filter: 4-cycle glitch rejected, 7-cycle pulse accepted with
    // enc_filt rising 2 + 5 + 1 cycles after the pin.
    do_reset();
    filt_thr   = FILT_W'(5);
    both_edges = 1'b0;
    steps(5);
    seen = 1'b0;
    enc  = 1'b1;
    repeat (4) begin step(); seen |= enc_filt; end
    enc = 1'b0;
    repeat (20) begin step(); seen |= enc_filt; end
    check("glitch_enc_filt", {31'd0, seen}, 0);
    check("glitch_edge_cnt", {28'd0, edge_cnt}, 0);
    rise_at = 0;
    enc     = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 7) enc = 1'b0;
      if (enc_filt === 1'b1 && rise_at == 0) rise_at = k;
    end
    check("pulse_latency",  rise_at, 8);
    check("pulse_edge_cnt", {28'd0, edge_cnt}, 1);
    check("pulse_fell",     {31'd0, enc_filt}, 0);

    // Timeout: measure 40, then stay quiet until the counter saturates.
    do_reset();
    filt_thr = '0;
    steps(10);
    enc = 1'b1; steps(20); enc = 1'b0; steps(20);
    enc = 1'b1; exp_q.push_back(40); steps(20); enc = 1'b0; steps(238);
    check("pre_timeout",  {31'd0, timeout}, 0);
    step();
    check("timeout_set",  {31'd0, timeout}, 1);
    check("period_held",  {24'd0, period}, 40);
    steps(40);
    check("timeout_stall", {31'd0, timeout}, 1);
    enc = 1'b1; steps(3);
    check("timeout_before_ev", {31'd0, timeout}, 1);
    step();
    check("timeout_cleared", {31'd0, timeout}, 0);
    steps(16); enc = 1'b0; steps(40);
    enc = 1'b1; exp_q.push_back(60); steps(10); enc = 1'b0; steps(20);
    check("after_stall_pending", exp_q.size(), 0);
    check("after_stall_period",  {24'd0, period}, 60);
    check("after_stall_edges",   {28'd0, edge_cnt}, 4);

    // Event on the saturation cycle: full-scale period, no timeout.
    do_reset();
    steps(10);
    seen = 1'b0;
    enc  = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      step();
      seen |= timeout;
      if (k == 100) enc = 1'b0;
    end
    enc = 1'b1;
    exp_q.push_back(255);
    repeat (10) begin step(); seen |= timeout; end
    enc = 1'b0;
    steps(10);
    check("max_no_timeout", {31'd0, seen}, 0);
    check("max_period",     {24'd0, period}, 255);
    check("max_pending",    exp_q.size(), 0);

    // Reset in the middle of a measurement (cnt = 40).
    do_reset();
    steps(10);
    enc = 1'b1; steps(20); enc = 1'b0; steps(30);
    enc = 1'b1; exp_q.push_back(50); steps(20); enc = 1'b0; steps(23);
    check("mid_pending", exp_q.size(), 0);
    rst = 1'b1;
    step();
    check("mid_rst_period",   {24'd0, period}, 0);
    check("mid_rst_valid",    {31'd0, period_valid}, 0);
    check("mid_rst_timeout",  {31'd0, timeout}, 0);
    check("mid_rst_edge_cnt", {28'd0, edge_cnt}, 0);
    check("mid_rst_enc_filt", {31'd0, enc_filt}, 0);
    rst = 1'b0;
    steps(10);
    enc = 1'b1; steps(20); enc = 1'b0; steps(50);
    enc = 1'b1; exp_q.push_back(70); steps(10); enc = 1'b0; steps(20);
    check("post_rst_pending", exp_q.size(), 0);
    check("post_rst_period",  {24'd0, period}, 70);
    check("post_rst_edges",   {28'd0, edge_cnt}, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
